vga_scanout: RTL
================

# vga_scanout

Reads the 9-bit-colour framebuffer that the on-screen drawers (pipeline, register and title drawers) write into, and turns it into a 640x480 @ 60 Hz VGA signal for the DAC. It generates the horizontal and vertical timing, issues one framebuffer read per visible pixel, and expands each 3-3-3 colour word to 8-8-8 RGB. It also gives drawers a frame-start strobe and a vertical-blank flag, so they can sequence their writes.

## Interface

Parameters:
- CLK_DIV, 2: system clocks per pixel; generates the internal pixel tick
- H_VISIBLE, 640; H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal timing, in pixels
- V_VISIBLE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical timing, in lines

Ports:
- clock, in, 1: system clock (50 MHz)
- resetn, in, 1: reset, asynchronous, active-low
- fb_addr, out, 19: framebuffer read address
- fb_rd, out, 1: framebuffer read strobe
- fb_data, in, 9: read data; [8:6]=R, [5:3]=G, [2:0]=B
- vga_r, vga_g, vga_b, out, 8 each: DAC colour
- vga_hs, vga_vs, out, 1 each: syncs, active-low
- vga_blank_n, out, 1: high in the active region
- vga_sync_n, out, 1: tied 0
- vga_clk, out, 1: pixel clock to the DAC
- frame_start, out, 1: one-clock pulse at the start of a frame
- in_vblank, out, 1: high while vcount >= V_VISIBLE

## Operation

- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - tick = (div == CLK_DIV-1).
  - vga_clk = (div >= CLK_DIV/2).
- Counters advance only on tick:
  - hcount runs 0..799.
  - At 799, hcount wraps to 0 and vcount increments.
  - vcount runs 0..524; at (799,524) both wrap to 0.
- Stage 0 is the counters.
  - visible0 = hcount < 640 && vcount < 480.
  - hs0 is low for hcount in 656..751.
  - vs0 is low for vcount in 490..491.
- Stage 1 is registered on tick.
  - fb_addr = vcount*640 + hcount when visible0, else it holds its last value.
  - fb_rd = visible0.
  - hs1, vs1 and visible1 are delayed copies of the stage-0 signals.
  - fb_addr range is 0..307199 and never exceeds it.
- Stage 2 is registered on the next tick.
  - fb_data is sampled on that tick; this is the memory-latency budget, so the memory must return data in at most CLK_DIV-1 clocks.
  - vga_hs = hs1, vga_vs = vs1, vga_blank_n = visible1.
  - RGB is the expanded fb_data when visible1, else 0.
- Colour expansion, per 3-bit channel c: out = {c, c, c[2:1]}. So 3'b111 gives 8'hFF and 3'b000 gives 8'h00.
- frame_start is high for exactly one clock: the clock in which the tick moves the counters from (799,524) to (0,0).
- in_vblank is decoded from vcount at stage 0. It is not delayed.
- No framebuffer writes originate here. Write-port arbitration lives in the framebuffer.

## Timing

- Reset values (held while resetn is low):
  - div, hcount, vcount: 0
  - fb_addr: 0, fb_rd: 0
  - vga_r, vga_g, vga_b: 0
  - vga_hs: 1, vga_vs: 1, vga_blank_n: 0
  - vga_clk: 0, frame_start: 0, in_vblank: 0
- Latency: the pixel at counter position (h,v) appears on the DAC outputs 2 ticks (2*CLK_DIV clocks) after the counters reach (h,v). Syncs and blank share the same 2-tick delay, so they stay aligned with the colour data.
- All outputs change only on tick clocks, except vga_clk, which follows div, and frame_start.
- Line period is 800 ticks. Frame period is 420000 ticks = 840000 clocks at CLK_DIV=2.
- Reset mid-frame: counters and pipeline clear immediately. The first tick after release is counter position (0,0). No partial or stale pixel is emitted, because blank stays low until stage 2 fills.
- fb_data is ignored whenever visible1 is low.

## Test plan

- Reset: assert resetn=0 mid-line. Required: all outputs at their reset values within the same clock. After release, the first fb_rd=1 carries fb_addr=0 at tick 1.
- Addressing: run one frame.
  - Required: 307200 fb_rd pulses in total.
  - Last address is 307199.
  - Address at (639,0) is 639; address at (0,1) is 640.
- Sync placement: measure vga_hs per line. Required: low for exactly 96 ticks, with the falling edge 656+2 ticks after hcount=0. vga_vs is low for exactly 2 lines (1600 ticks).
- Colour: drive fb_data = 9'b111000000, then 9'b010101001. Required: RGB of FF/00/00, then 49/B6/24. During blank, RGB is 00/00/00.
- Frame strobe: count clocks between frame_start pulses. Required: exactly 840000, each pulse one clock wide. in_vblank is high for 45 lines per frame.
- Latency: a memory model returns addr[8:0] as data. Required: the first visible DAC pixel of line 0 equals 9'd0 expanded, 2 ticks after counters reach (0,0), coincident with vga_blank_n rising.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout
// -----------
// Scans the 9-bit (3-3-3) framebuffer out as a 640x480 @ 60 Hz VGA signal.
// A clock divider produces one pixel tick every CLK_DIV system clocks; the
// horizontal/vertical counters, the read stage and the DAC stage all advance
// only on that tick.
//
// Pipeline (one stage per tick):
//   stage 0 : hcount/vcount and the decodes derived from them
//   stage 1 : framebuffer read request (fb_addr/fb_rd) plus delayed syncs
//   stage 2 : fb_data sampled, colour expanded, syncs/blank driven to the DAC
// A pixel at counter position (h,v) reaches the DAC two ticks after the
// counters reach (h,v); syncs and blank travel with it.
//
// Framebuffer read strobe: fb_rd is a plain request with no back-pressure.
// While fb_rd is high, fb_addr is stable until the next tick, and the memory
// must present the word on fb_data within CLK_DIV-1 clocks; it is sampled on
// the following tick.
//
// Ports:
//   clock, resetn        system clock, asynchronous active-low reset
//   fb_addr, fb_rd       framebuffer read address / read strobe
//   fb_data              read data, [8:6]=R [5:3]=G [2:0]=B
//   vga_r/g/b            8-bit DAC colour (0 outside the active region)
//   vga_hs, vga_vs       active-low syncs
//   vga_blank_n          high in the active region
//   vga_sync_n           tied low
//   vga_clk              pixel clock to the DAC
//   frame_start          one-clock pulse as the counters wrap to (0,0)
//   in_vblank            high while vcount is outside the visible lines
module vga_scanout #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clock,
  input  logic        resetn,
  output logic [18:0] fb_addr,
  output logic        fb_rd,
  input  logic [8:0]  fb_data,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        vga_clk,
  output logic        frame_start,
  output logic        in_vblank
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF     = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_C      = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_C      = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // 3-bit channel to 8 bits by bit replication, so full scale maps to 8'hFF.
  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  // ---------------- divider and counters (stage 0) ----------------
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          tick;
  logic          h_last, v_last;

  assign tick   = (div_q == DIV_LAST);
  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);
  assign div_d  = tick ? '0 : div_q + DW'(1);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  // Stage-0 decodes.
  logic        visible0, hs0, vs0;
  logic [18:0] addr0;

  assign visible0 = (h_q < H_VIS_C) && (v_q < V_VIS_C);
  assign hs0      = !((h_q >= H_SYNC_FIRST) && (h_q <= H_SYNC_LAST));
  assign vs0      = !((v_q >= V_SYNC_FIRST) && (v_q <= V_SYNC_LAST));
  assign addr0    = (19'(v_q) * 19'(H_VISIBLE)) + 19'(h_q);

  // ---------------- stage 1: framebuffer read request ----------------
  logic [18:0] addr_q;
  logic        rd_q, hs1_q, vs1_q, vis1_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      rd_q   <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      vis1_q <= 1'b0;
    end else if (tick) begin
      // The address only moves for visible pixels, so it never leaves the
      // framebuffer range and holds during blanking.
      if (visible0) begin
        addr_q <= addr0;
      end
      rd_q   <= visible0;
      hs1_q  <= hs0;
      vs1_q  <= vs0;
      vis1_q <= visible0;
    end
  end

  // ---------------- stage 2: DAC outputs ----------------
  logic [7:0] r_q, g_q, b_q;
  logic       hs2_q, vs2_q, blank_n_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_q       <= 8'h00;
      g_q       <= 8'h00;
      b_q       <= 8'h00;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
      blank_n_q <= 1'b0;
    end else if (tick) begin
      // fb_data is meaningless unless stage 1 issued a read.
      r_q       <= vis1_q ? expand3(fb_data[8:6]) : 8'h00;
      g_q       <= vis1_q ? expand3(fb_data[5:3]) : 8'h00;
      b_q       <= vis1_q ? expand3(fb_data[2:0]) : 8'h00;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      blank_n_q <= vis1_q;
    end
  end

  assign fb_addr     = addr_q;
  assign fb_rd       = rd_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hs      = hs2_q;
  assign vga_vs      = vs2_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = (div_q >= DIV_HALF);
  // High during the clock whose tick wraps the counters from the last
  // position of the frame back to (0,0).
  assign frame_start = tick && h_last && v_last;
  // Decoded straight from the counters so drawers see blanking without delay.
  assign in_vblank   = (v_q >= V_VIS_C);

endmodule
